// File: rtl/reg_file_pkg.sv
// Shared types and constants for the register-file write-back path.
package reg_file_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_REQ = 2;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  // One pending write-back: destination index plus data.
  typedef struct packed {
    reg_idx_t  idx;
    reg_data_t data;
  } wb_req_t;

  localparam reg_idx_t X0 = '0;

  // x0 is hard-wired to zero, so writes to it are dropped.
  function automatic logic is_x0(input reg_idx_t r);
    return r == X0;
  endfunction

endpackage

// File: rtl/reg_file_wb_arbiter_skid.sv
// One-entry skid buffer for a write-back requester.
// Drops writes to x0 after completing the handshake, and frees its slot
// on the same edge it is granted so a fresh request can refill it.
module wb_skid_buf #(
  parameter int DATA_W = reg_file_pkg::DATA_W,
  parameter int ADDR_W = reg_file_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_reg,
  input  logic [DATA_W-1:0] in_data,
  input  logic              grant,
  output logic              full,
  output logic [ADDR_W-1:0] out_reg,
  output logic [DATA_W-1:0] out_data
);

  logic              full_q, full_d;
  logic [ADDR_W-1:0] reg_q, reg_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              load;

  // Ready depends only on registered state and the grant, never on valid.
  assign in_ready = ~full_q | grant;

  // Load on an accepted non-x0 request; otherwise a grant empties the slot.
  always_comb begin
    load   = in_valid & in_ready & (in_reg != '0);
    full_d = (full_q & ~grant) | load;
    reg_d  = load ? in_reg  : reg_q;
    data_d = load ? in_data : data_q;
  end

  // Buffer state; reset discards any held write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      reg_q  <= '0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      reg_q  <= reg_d;
      data_q <= data_d;
    end
  end

  assign full     = full_q;
  assign out_reg  = reg_q;
  assign out_data = data_q;

endmodule

// File: rtl/reg_file_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port between the
// ALU (requester 0) and load unit (requester 1) write-backs.
// Optional feature macro: WB_ARB_FWD_EN adds two forwarding lookup ports
// that return the newest pending value for a source register.
module reg_file_wb_arbiter
  import reg_file_pkg::*;
#(
  parameter int DATA_W = reg_file_pkg::DATA_W,
  parameter int ADDR_W = reg_file_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_reg,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_reg,
  input  logic [DATA_W-1:0] req1_data,
`ifdef WB_ARB_FWD_EN
  input  logic [ADDR_W-1:0] rd_reg_1,
  input  logic [ADDR_W-1:0] rd_reg_2,
  output logic              fwd_hit_1,
  output logic              fwd_hit_2,
  output logic [DATA_W-1:0] fwd_data_1,
  output logic [DATA_W-1:0] fwd_data_2,
`endif
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_reg,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy
);

  logic [NUM_REQ-1:0]             req_valid, req_ready, full, grant;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_reg, sk_reg;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_data, sk_data;

  logic              last_grant_q, last_grant_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_reg_q, wr_reg_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  assign req_valid = {req1_valid, req0_valid};
  assign req_reg   = {req1_reg, req0_reg};
  assign req_data  = {req1_data, req0_data};
  assign req0_ready = req_ready[0];
  assign req1_ready = req_ready[1];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_skid
      wb_skid_buf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (req_valid[gi]),
        .in_ready (req_ready[gi]),
        .in_reg   (req_reg[gi]),
        .in_data  (req_data[gi]),
        .grant    (grant[gi]),
        .full     (full[gi]),
        .out_reg  (sk_reg[gi]),
        .out_data (sk_data[gi])
      );
    end
  endgenerate

  // Round-robin grant from registered state only; a tie goes to the
  // requester that did not win last time.
  always_comb begin
    grant[0] = full[0] & (~full[1] | last_grant_q);
    grant[1] = full[1] & (~full[0] | ~last_grant_q);
  end

  // Next write-stage contents and round-robin pointer.
  always_comb begin
    wr_en_d      = |grant;
    wr_reg_d     = wr_reg_q;
    wr_data_d    = wr_data_q;
    last_grant_d = last_grant_q;
    if (grant[0]) begin
      wr_reg_d     = sk_reg[0];
      wr_data_d    = sk_data[0];
      last_grant_d = 1'b0;
    end else if (grant[1]) begin
      wr_reg_d     = sk_reg[1];
      wr_data_d    = sk_data[1];
      last_grant_d = 1'b1;
    end
  end

  // Registered write stage; reset kills any in-flight write at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q      <= 1'b0;
      wr_reg_q     <= '0;
      wr_data_q    <= '0;
      last_grant_q <= 1'b1;
    end else begin
      wr_en_q      <= wr_en_d;
      wr_reg_q     <= wr_reg_d;
      wr_data_q    <= wr_data_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_reg  = wr_reg_q;
  assign wr_data = wr_data_q;
  assign busy    = |full | wr_en_q;

`ifdef WB_ARB_FWD_EN
  logic [1:0][ADDR_W-1:0] rd_reg;
  logic [1:0]             fwd_hit;
  logic [1:0][DATA_W-1:0] fwd_data;
  logic                   newest;

  assign rd_reg = {rd_reg_2, rd_reg_1};

  // With both skids full the one that loses arbitration now is written
  // last, so it holds the newest value; the write stage is always oldest.
  assign newest = full[1] & full[0] & grant[0];

  // Forwarding lookup: newest skid, then the other skid, then write stage.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      fwd_hit[k]  = 1'b0;
      fwd_data[k] = '0;
      if (rd_reg[k] != '0) begin
        if (full[newest] && sk_reg[newest] == rd_reg[k]) begin
          fwd_hit[k]  = 1'b1;
          fwd_data[k] = sk_data[newest];
        end else if (full[~newest] && sk_reg[~newest] == rd_reg[k]) begin
          fwd_hit[k]  = 1'b1;
          fwd_data[k] = sk_data[~newest];
        end else if (wr_en_q && wr_reg_q == rd_reg[k]) begin
          fwd_hit[k]  = 1'b1;
          fwd_data[k] = wr_data_q;
        end
      end
    end
  end

  assign fwd_hit_1  = fwd_hit[0];
  assign fwd_hit_2  = fwd_hit[1];
  assign fwd_data_1 = fwd_data[0];
  assign fwd_data_2 = fwd_data[1];
`endif

endmodule

// File: tb/tb_reg_file_wb_arbiter.sv
// Directed bench for reg_file_wb_arbiter with a register-file model.
module tb_reg_file_wb_arbiter;
  import reg_file_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk, rst_n;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [AW-1:0] req0_reg, req1_reg, wr_reg;
  logic [DW-1:0] req0_data, req1_data, wr_data;
  logic          wr_en, busy;
`ifdef WB_ARB_FWD_EN
  logic [AW-1:0] rd_reg_1, rd_reg_2;
  logic          fwd_hit_1, fwd_hit_2;
  logic [DW-1:0] fwd_data_1, fwd_data_2;
`endif

  reg_file_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_reg   (req0_reg),
    .req0_data  (req0_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_reg   (req1_reg),
    .req1_data  (req1_data),
`ifdef WB_ARB_FWD_EN
    .rd_reg_1   (rd_reg_1),
    .rd_reg_2   (rd_reg_2),
    .fwd_hit_1  (fwd_hit_1),
    .fwd_hit_2  (fwd_hit_2),
    .fwd_data_1 (fwd_data_1),
    .fwd_data_2 (fwd_data_2),
`endif
    .wr_en      (wr_en),
    .wr_reg     (wr_reg),
    .wr_data    (wr_data),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model plus a log of every write it captured.
  typedef struct {
    int            cyc;
    logic [AW-1:0] r;
    logic [DW-1:0] d;
  } wlog_t;

  logic [DW-1:0] rf [32] = '{default: '0};
  wlog_t         wlog[$];
  int            cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (wr_en) begin
      rf[wr_reg] <= wr_data;
      wlog.push_back('{cyc, wr_reg, wr_data});
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_drain"}, busy, 1'b0);
  endtask

  // Contention stimulus: requester 0 writes x1..x4, requester 1 x11..x14.
  wb_req_t vec0 [4] = '{'{5'd1,  32'h101}, '{5'd2,  32'h102}, '{5'd3,  32'h103}, '{5'd4,  32'h104}};
  wb_req_t vec1 [4] = '{'{5'd11, 32'h211}, '{5'd12, 32'h212}, '{5'd13, 32'h213}, '{5'd14, 32'h214}};
  logic [AW-1:0] exp_seq [8] = '{5'd1, 5'd11, 5'd2, 5'd12, 5'd3, 5'd13, 5'd4, 5'd14};

  initial begin
    int i0, i1, st0, st1, n, stalls;
    logic a0, a1;

    rst_n = 1'b0;
    idle();
    req0_reg = '0; req0_data = '0; req1_reg = '0; req1_data = '0;
`ifdef WB_ARB_FWD_EN
    rd_reg_1 = '0; rd_reg_2 = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_en",   wr_en, 1'b0);
    chk("rst_wr_reg",  wr_reg, 5'd0);
    chk("rst_wr_data", wr_data, 32'h0);
    chk("rst_busy",    busy, 1'b0);
    chk("rst_rdy0",    req0_ready, 1'b1);
    chk("rst_rdy1",    req1_ready, 1'b1);
    rst_n = 1'b1;
    tick();

    // Single uncontended write: accept at N, write stage busy N+2 only.
    req0_valid = 1'b1; req0_reg = 5'd5; req0_data = 32'hDEADBEEF;
    wlog.delete();
    tick();
    idle();
    chk("single_busy_n1",  busy, 1'b1);
    chk("single_wren_n1",  wr_en, 1'b0);
    tick();
    chk("single_wren_n2",  wr_en, 1'b1);
    chk("single_wreg_n2",  wr_reg, 5'd5);
    chk("single_wdata_n2", wr_data, 32'hDEADBEEF);
    tick();
    chk("single_wren_n3",  wr_en, 1'b0);
    chk("single_busy_n3",  busy, 1'b0);
    chk("single_rf5",      rf[5], 32'hDEADBEEF);
    chk("single_nwr",      wlog.size(), 1);

    // Reset with both skids loaded and a write in the stage.
    req0_valid = 1'b1; req0_reg = 5'd20; req0_data = 32'hA20;
    req1_valid = 1'b1; req1_reg = 5'd21; req1_data = 32'hA21;
    tick();
    idle();
    chk("mid_busy",   busy, 1'b1);
    chk("mid_rdy0",   req0_ready, 1'b0);
    chk("mid_rdy1",   req1_ready, 1'b1);
    tick();
    chk("mid_wren",   wr_en, 1'b1);
    chk("mid_wreg",   wr_reg, 5'd21);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_wren", wr_en, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    #4 rst_n = 1'b1;
    #1;
    chk("mid_rel_rdy0", req0_ready, 1'b1);
    chk("mid_rel_rdy1", req1_ready, 1'b1);
    repeat (3) tick();
    chk("mid_rf20", rf[20], 32'h0);
    chk("mid_rf21", rf[21], 32'h0);

    // Both requesters streaming: grants alternate starting with requester 0.
    wlog.delete();
    i0 = 0; i1 = 0; st0 = 0; st1 = 0; n = 0;
    while ((i0 < 4 || i1 < 4 || busy) && n < 40) begin
      req0_valid = (i0 < 4);
      req1_valid = (i1 < 4);
      if (i0 < 4) begin req0_reg = vec0[i0].idx; req0_data = vec0[i0].data; end
      if (i1 < 4) begin req1_reg = vec1[i1].idx; req1_data = vec1[i1].data; end
      a0 = req0_valid & req0_ready;
      a1 = req1_valid & req1_ready;
      if (req0_valid && !req0_ready) st0++;
      if (req1_valid && !req1_ready) st1++;
      tick();
      if (a0) i0++;
      if (a1) i1++;
      n++;
    end
    idle();
    chk("cont_timeout", n < 40, 1'b1);
    chk("cont_nwr", wlog.size(), 8);
    for (int k = 0; k < 8; k++)
      if (k < wlog.size()) chk($sformatf("cont_seq%0d", k), wlog[k].r, exp_seq[k]);
    chk("cont_stall0", st0, 2);
    chk("cont_stall1", st1, 3);
    chk("cont_rf4",  rf[4],  32'h104);
    chk("cont_rf14", rf[14], 32'h214);

    // Same register from both sides after requester 1 won last.
    wlog.delete();
    req0_valid = 1'b1; req0_reg = 5'd7; req0_data = 32'h1;
    req1_valid = 1'b1; req1_reg = 5'd7; req1_data = 32'h2;
`ifdef WB_ARB_FWD_EN
    rd_reg_1 = 5'd7;
`endif
    tick();
    idle();
`ifdef WB_ARB_FWD_EN
    chk("same_fwd_hit_a",  fwd_hit_1, 1'b1);
    chk("same_fwd_data_a", fwd_data_1, 32'h2);
`endif
    tick();
    chk("same_wdata_1", wr_data, 32'h1);
`ifdef WB_ARB_FWD_EN
    chk("same_fwd_data_b", fwd_data_1, 32'h2);
`endif
    tick();
    chk("same_wreg_2",  wr_reg, 5'd7);
    chk("same_wdata_2", wr_data, 32'h2);
    tick();
    chk("same_rf7", rf[7], 32'h2);
    chk("same_nwr", wlog.size(), 2);
`ifdef WB_ARB_FWD_EN
    chk("same_fwd_miss",  fwd_hit_1, 1'b0);
    chk("same_fwd_zero",  fwd_data_1, 32'h0);
    rd_reg_1 = '0;
`endif

    // Write to x0: handshake completes, nothing reaches the register file.
    wlog.delete();
    req1_valid = 1'b1; req1_reg = 5'd0; req1_data = 32'hFFFFFFFF;
    chk("x0_rdy1", req1_ready, 1'b1);
    tick();
    idle();
    chk("x0_busy", busy, 1'b0);
    repeat (3) tick();
    chk("x0_nwr", wlog.size(), 0);
    chk("x0_rf0", rf[0], 32'h0);

    // Single requester streaming eight back-to-back writes.
    wlog.delete();
    stalls = 0;
    for (int k = 1; k <= 8; k++) begin
      req0_valid = 1'b1; req0_reg = AW'(k); req0_data = 32'h300 + k;
      if (!req0_ready) stalls++;
      tick();
    end
    idle();
    drain("stream");
    chk("stream_stalls", stalls, 0);
    chk("stream_nwr", wlog.size(), 8);
    if (wlog.size() == 8) begin
      chk("stream_back2back", wlog[7].cyc - wlog[0].cyc, 7);
      chk("stream_first", wlog[0].r, 5'd1);
      chk("stream_last",  wlog[7].r, 5'd8);
    end
    chk("stream_rf8", rf[8], 32'h308);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
